// File: rtl/mercury_seg_arb.sv
// Two-requester arbiter for a four-digit seven-segment display.
// Requester 0 always wins and may preempt requester 1; the accepted
// content is decoded once at accept time and held for HOLD_CYCLES cycles.
module mercury_seg_arb #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        app_clk,
  input  logic        app_arst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_dots,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_dots,
  output logic        req1_ready,
  input  logic        blank_lz,
  output logic [6:0]  A_TO_G0_out,
  output logic [6:0]  A_TO_G1_out,
  output logic [6:0]  A_TO_G2_out,
  output logic [6:0]  A_TO_G3_out,
  output logic [3:0]  DOTS_out,
  output logic        enable_out,
  output logic [1:0]  owner_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_t;

  // Counter reload: the display stays lit for HOLD_CYCLES cycles after accept.
  localparam logic [25:0] LP_RELOAD = 26'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [25:0] r_cnt;
  logic [6:0]  r_seg0;
  logic [6:0]  r_seg1;
  logic [6:0]  r_seg2;
  logic [6:0]  r_seg3;
  logic [3:0]  r_dots;
  logic        r_enable;
  logic [1:0]  r_owner;

  logic        w_acc0;
  logic        w_acc1;
  logic [15:0] w_selData;
  logic [3:0]  w_selDots;
  logic [3:0]  w_nibZero;
  logic [2:0]  w_blank;
  logic [6:0]  w_seg0;
  logic [6:0]  w_seg1;
  logic [6:0]  w_seg2;
  logic [6:0]  w_seg3;

  // Hex nibble to active-high segments, bit6 = a down to bit0 = g.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  // Requester 0 is never stalled; requester 1 yields to requester 0 and to SHOW0.
  assign req0_ready = 1'b1;
  assign req1_ready = (r_state != SHOW0) && !req0_valid;

  assign w_acc0 = req0_valid;
  assign w_acc1 = req1_valid && req1_ready;

  // Pick the winning offer and build its blanked segment patterns.
  always_comb begin
    w_selData = w_acc0 ? req0_data : req1_data;
    w_selDots = w_acc0 ? req0_dots : req1_dots;
    w_nibZero[0] = (w_selData[15:12] == 4'h0);
    w_nibZero[1] = (w_selData[11:8]  == 4'h0);
    w_nibZero[2] = (w_selData[7:4]   == 4'h0);
    w_nibZero[3] = (w_selData[3:0]   == 4'h0);
    w_blank[0] = blank_lz && w_nibZero[0];
    w_blank[1] = w_blank[0] && w_nibZero[1];
    w_blank[2] = w_blank[1] && w_nibZero[2];
    w_seg0 = w_blank[0] ? 7'h00 : f_decode(w_selData[15:12]);
    w_seg1 = w_blank[1] ? 7'h00 : f_decode(w_selData[11:8]);
    w_seg2 = w_blank[2] ? 7'h00 : f_decode(w_selData[7:4]);
    w_seg3 = f_decode(w_selData[3:0]);
  end

  // Arbitration FSM with hold counter and registered display outputs.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      r_state  <= IDLE;
      r_cnt    <= 26'd0;
      r_seg0   <= 7'h00;
      r_seg1   <= 7'h00;
      r_seg2   <= 7'h00;
      r_seg3   <= 7'h00;
      r_dots   <= 4'h0;
      r_enable <= 1'b0;
      r_owner  <= 2'b00;
    end else if (w_acc0 || w_acc1) begin
      r_state  <= w_acc0 ? SHOW0 : SHOW1;
      r_cnt    <= LP_RELOAD;
      r_seg0   <= w_seg0;
      r_seg1   <= w_seg1;
      r_seg2   <= w_seg2;
      r_seg3   <= w_seg3;
      r_dots   <= w_selDots;
      r_enable <= 1'b1;
      r_owner  <= w_acc0 ? 2'b01 : 2'b10;
    end else if (r_state != IDLE && r_cnt == 26'd0) begin
      r_state  <= IDLE;
      r_seg0   <= 7'h00;
      r_seg1   <= 7'h00;
      r_seg2   <= 7'h00;
      r_seg3   <= 7'h00;
      r_dots   <= 4'h0;
      r_enable <= 1'b0;
      r_owner  <= 2'b00;
    end else if (r_cnt != 26'd0) begin
      r_cnt <= r_cnt - 26'd1;
    end
  end

  assign A_TO_G0_out = r_seg0;
  assign A_TO_G1_out = r_seg1;
  assign A_TO_G2_out = r_seg2;
  assign A_TO_G3_out = r_seg3;
  assign DOTS_out    = r_dots;
  assign enable_out  = r_enable;
  assign owner_out   = r_owner;

endmodule

// File: tb/tb_mercury_seg_arb.sv
// Directed and random checks of mercury_seg_arb against a cycle-count model.
module tb_mercury_seg_arb;

  localparam int HOLD = 8;

  logic        app_clk;
  logic        app_arst;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic [3:0]  req0_dots;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic [3:0]  req1_dots;
  logic        req1_ready;
  logic        blank_lz;
  logic [6:0]  seg0;
  logic [6:0]  seg1;
  logic [6:0]  seg2;
  logic [6:0]  seg3;
  logic [3:0]  DOTS_out;
  logic        enable_out;
  logic [1:0]  owner_out;

  int nAssert = 0;
  int nFail   = 0;

  logic [6:0] segLut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: who owns the display, how many lit cycles remain, content.
  int         mOwner;
  int         mLeft;
  logic [6:0] mSeg [4];
  logic [3:0] mDots;

  mercury_seg_arb #(.HOLD_CYCLES(HOLD)) dut (
    .app_clk     (app_clk),
    .app_arst    (app_arst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_dots   (req0_dots),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_dots   (req1_dots),
    .req1_ready  (req1_ready),
    .blank_lz    (blank_lz),
    .A_TO_G0_out (seg0),
    .A_TO_G1_out (seg1),
    .A_TO_G2_out (seg2),
    .A_TO_G3_out (seg3),
    .DOTS_out    (DOTS_out),
    .enable_out  (enable_out),
    .owner_out   (owner_out)
  );

  // Free-running 10 ns clock.
  initial begin
    app_clk = 1'b0;
    forever #5 app_clk = ~app_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // A digit is blank when every nibble from digit 0 through it is zero.
  function automatic logic [6:0] refDigit(input logic [15:0] d, input logic bl, input int i);
    logic [15:0] upper;
    upper = d >> (12 - 4 * i);
    if (bl && i < 3 && upper == 16'h0) return 7'h00;
    return segLut[upper[3:0]];
  endfunction

  task automatic modelClear();
    mOwner = 0;
    mLeft  = 0;
    for (int i = 0; i < 4; i++) mSeg[i] = 7'h00;
    mDots = 4'h0;
  endtask

  task automatic modelLoad(input logic [15:0] d, input logic [3:0] dots, input int owner);
    mOwner = owner;
    mLeft  = HOLD;
    for (int i = 0; i < 4; i++) mSeg[i] = refDigit(d, blank_lz, i);
    mDots = dots;
  endtask

  task automatic modelStep();
    if (req0_valid) modelLoad(req0_data, req0_dots, 1);
    else if (req1_valid && mOwner != 1) modelLoad(req1_data, req1_dots, 2);
    else if (mOwner != 0) begin
      mLeft--;
      if (mLeft == 0) modelClear();
    end
  endtask

  task automatic checkAll();
    checkOutput("enable", 32'(enable_out), 32'(mOwner != 0));
    checkOutput("owner", 32'(owner_out), mOwner);
    checkOutput("dots", 32'(DOTS_out), 32'(mDots));
    checkOutput("seg0", 32'(seg0), 32'(mSeg[0]));
    checkOutput("seg1", 32'(seg1), 32'(mSeg[1]));
    checkOutput("seg2", 32'(seg2), 32'(mSeg[2]));
    checkOutput("seg3", 32'(seg3), 32'(mSeg[3]));
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] d0, input logic [3:0] p0,
                               input logic v1, input logic [15:0] d1, input logic [3:0] p1,
                               input logic bl);
    req0_valid = v0; req0_data = d0; req0_dots = p0;
    req1_valid = v1; req1_data = d1; req1_dots = p1;
    blank_lz   = bl;
  endtask

  // One clock: check ready signals, advance model, check registered outputs.
  task automatic tick();
    #1;
    checkOutput("req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("req1_ready", 32'(req1_ready), 32'(!req0_valid && mOwner != 1));
    modelStep();
    @(posedge app_clk);
    #1;
    checkAll();
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    int n;
    idleInputs();
    modelClear();
    app_arst = 1'b1;
    #1;
    checkAll();
    @(posedge app_clk);
    #1;
    app_arst = 1'b0;

    // Test 1: req1 accepted in the very first cycle after reset release.
    $display("[TB] test 1: req1 from IDLE");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 16'h12AF, 4'b0001, 1'b0);
    tick();
    checkOutput("t1_seg0", 32'(seg0), 32'h30);
    checkOutput("t1_seg1", 32'(seg1), 32'h6D);
    checkOutput("t1_seg2", 32'(seg2), 32'h77);
    checkOutput("t1_seg3", 32'(seg3), 32'h47);
    checkOutput("t1_owner", 32'(owner_out), 32'h2);
    idleInputs();
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (k == HOLD - 1) checkOutput("t1_lit", 32'(enable_out), 32'd1);
      if (k == HOLD) checkOutput("t1_off", 32'(enable_out), 32'd0);
    end

    // Test 2: simultaneous offers; req1 waits for SHOW0 expiry.
    $display("[TB] test 2: simultaneous valids");
    applyStimulus(1'b1, 16'hBEEF, 4'b1010, 1'b1, 16'h4321, 4'b0101, 1'b0);
    tick();
    checkOutput("t2_owner0", 32'(owner_out), 32'h1);
    req0_valid = 1'b0;
    n = 0;
    while (owner_out != 2'b10 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t2_wait", n, HOLD + 1);

    // Test 3: req0 preempts three cycles into SHOW1.
    $display("[TB] test 3: preemption");
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    applyStimulus(1'b1, 16'h0A0B, 4'b0011, 1'b0, 16'h0, 4'h0, 1'b0);
    tick();
    checkOutput("t3_owner", 32'(owner_out), 32'h1);
    req0_valid = 1'b0;
    n = 0;
    while (enable_out && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t3_hold", n, HOLD);

    // Test 4: leading-zero blanking, sampled only at accept.
    $display("[TB] test 4: blanking");
    applyStimulus(1'b1, 16'h0000, 4'b1000, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    checkOutput("t4a_seg0", 32'(seg0), 32'h00);
    checkOutput("t4a_seg2", 32'(seg2), 32'h00);
    checkOutput("t4a_seg3", 32'(seg3), 32'h7E);
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0);
    tick();
    checkOutput("t4_keep_seg0", 32'(seg0), 32'h00);
    applyStimulus(1'b1, 16'h0305, 4'b0000, 1'b0, 16'h0, 4'h0, 1'b1);
    tick();
    checkOutput("t4b_seg0", 32'(seg0), 32'h00);
    checkOutput("t4b_seg1", 32'(seg1), 32'h79);
    checkOutput("t4b_seg2", 32'(seg2), 32'h7E);
    checkOutput("t4b_seg3", 32'(seg3), 32'h5B);
    idleInputs();
    for (int k = 0; k < HOLD; k++) tick();

    // Test 5: req1 re-offers exactly on the expiry cycle.
    $display("[TB] test 5: refresh at expiry");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 16'h5678, 4'b0110, 1'b0);
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < HOLD - 1; k++) tick();
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 16'h9ABC, 4'b1001, 1'b0);
    tick();
    checkOutput("t5_lit", 32'(enable_out), 32'd1);
    checkOutput("t5_seg0", 32'(seg0), 32'h7B);
    req1_valid = 1'b0;
    n = 0;
    while (enable_out && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t5_hold", n, HOLD);

    // Test 6: asynchronous reset pulse between edges during SHOW0.
    $display("[TB] test 6: async reset");
    applyStimulus(1'b1, 16'h1111, 4'b1111, 1'b0, 16'h0, 4'h0, 1'b0);
    tick();
    req0_valid = 1'b0;
    tick();
    #2;
    app_arst = 1'b1;
    modelClear();
    #1;
    checkAll();
    app_arst = 1'b0;
    #1;
    tick();

    // Random traffic against the model.
    $display("[TB] random phase");
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(7) == 0, 16'($urandom), 4'($urandom),
                    $urandom_range(2) == 0, 16'($urandom_range(3) == 0 ? $urandom_range(255) : $urandom),
                    4'($urandom), 1'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
